// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes, FSM encodings and limits.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int CPB_MIN = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    // Mode 11 is treated as "none", so only the two explicit encodings enable parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter with a mid-start strobe and a bit strobe; intended to be shared with a TX.
module uart_rx_bit_timer #(
    parameter int CPB_W = 32
) (
    input  logic             i_Clock,
    input  logic             rst_n,
    input  logic             i_Clear,
    input  logic             i_Enable,
    input  logic [CPB_W-1:0] i_Cpb,
    output logic             o_Mid_Strobe,
    output logic             o_Bit_Strobe
);

    logic [CPB_W-1:0] r_count;
    logic [CPB_W-1:0] w_last;
    logic [CPB_W-1:0] w_mid;

    assign w_last = i_Cpb - CPB_W'(1);
    assign w_mid  = w_last >> 1;

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_Clear) begin
            r_count <= '0;
        end else if (i_Enable) begin
            r_count <= (r_count == w_last) ? '0 : r_count + CPB_W'(1);
        end
    end

    // Strobes are not gated by i_Clear: the FSM derives i_Clear from them.
    assign o_Mid_Strobe = i_Enable && (r_count == w_mid);
    assign o_Bit_Strobe = i_Enable && (r_count == w_last);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime parity/stop/baud, majority-vote sampling,
// error reporting and a one-entry valid/ready holding buffer.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int CPB_W       = 32,
    parameter int DEFAULT_CPB = 16
) (
    input  logic                 i_Clock,
    input  logic                 rst_n,
    input  logic [CPB_W-1:0]     i_Clks_Per_Bit,
    input  logic                 i_Ld_Cfg,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Two_Stop,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun,
    output logic                 o_Busy,
    output rx_state_t            o_Dbg_State
);

    localparam int IDX_W = 4;

    rx_state_t            r_state, w_state_nxt;
    logic [1:0]           r_sync;
    logic [2:0]           r_win;
    logic [CPB_W-1:0]     r_cpb;
    logic [1:0]           r_par_mode;
    logic                 r_two_stop;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_perr, r_par_bit, r_ferr, r_stop1_zero;
    logic [DATA_BITS-1:0] r_buf_data;
    logic                 r_buf_valid, r_buf_perr, r_buf_ferr, r_buf_brk, r_overrun;

    logic                 w_bit, w_par_en, w_mid_stb, w_bit_stb;
    logic                 w_tmr_clear, w_tmr_en, w_complete, w_handshake;
    logic                 w_ferr_fin, w_s1z_fin, w_brk;
    logic [CPB_W-1:0]     w_cpb_clamped;

    // Valid/ready: a transfer happens on any clock edge where o_Rx_Valid and
    // i_Rx_Ready are both high; o_Rx_Valid never drops without a transfer.
    assign w_handshake   = r_buf_valid && i_Rx_Ready;
    assign w_bit         = (r_win[0] & r_win[1]) | (r_win[0] & r_win[2]) | (r_win[1] & r_win[2]);
    assign w_par_en      = parity_enabled(r_par_mode);
    assign w_tmr_en      = (r_state != ST_IDLE);
    assign w_cpb_clamped = (i_Clks_Per_Bit < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN) : i_Clks_Per_Bit;

    uart_rx_bit_timer #(.CPB_W(CPB_W)) u_timer (
        .i_Clock      (i_Clock),
        .rst_n        (rst_n),
        .i_Clear      (w_tmr_clear),
        .i_Enable     (w_tmr_en),
        .i_Cpb        (r_cpb),
        .o_Mid_Strobe (w_mid_stb),
        .o_Bit_Strobe (w_bit_stb)
    );

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_win      <= 3'b111;
            r_cpb      <= CPB_W'(DEFAULT_CPB);
            r_par_mode <= PAR_NONE;
            r_two_stop <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_sync  <= {r_sync[0], i_Rx_Serial};
            r_win   <= {r_win[1:0], r_sync[1]};
            r_state <= w_state_nxt;
            if (i_Ld_Cfg && (r_state == ST_IDLE)) begin
                r_cpb      <= w_cpb_clamped;
                r_par_mode <= i_Parity_Mode;
                r_two_stop <= i_Two_Stop;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clear = 1'b0;
        w_complete  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_tmr_clear = 1'b1;
                if (!r_sync[1]) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_mid_stb) begin
                    if (w_bit) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tmr_clear = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_bit_stb && (r_bit_idx == IDX_W'(DATA_BITS - 1)))
                    w_state_nxt = w_par_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (w_bit_stb) w_state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (w_bit_stb) begin
                    if (r_two_stop) begin
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_complete  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (w_bit_stb) begin
                    w_state_nxt = ST_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_perr       <= 1'b0;
            r_par_bit    <= 1'b0;
            r_ferr       <= 1'b0;
            r_stop1_zero <= 1'b0;
        end else begin
            if ((r_state == ST_START) && w_mid_stb && !w_bit) begin
                r_bit_idx    <= '0;
                r_perr       <= 1'b0;
                r_par_bit    <= 1'b0;
                r_ferr       <= 1'b0;
                r_stop1_zero <= 1'b0;
            end
            if (w_bit_stb && (r_state == ST_DATA)) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_bit_stb && (r_state == ST_PARITY)) begin
                r_perr    <= ((^r_shift) ^ w_bit) != (r_par_mode == PAR_ODD);
                r_par_bit <= w_bit;
            end
            if (w_bit_stb && (r_state == ST_STOP1)) begin
                r_ferr       <= ~w_bit;
                r_stop1_zero <= ~w_bit;
            end
        end
    end

    // On completion the final stop bit is still combinational, so fold it in here.
    assign w_ferr_fin = (r_state == ST_STOP1) ? ~w_bit : (r_ferr | ~w_bit);
    assign w_s1z_fin  = (r_state == ST_STOP1) ? ~w_bit : r_stop1_zero;
    assign w_brk      = (r_shift == '0) && (!w_par_en || !r_par_bit) && w_s1z_fin;

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
            r_buf_perr  <= 1'b0;
            r_buf_ferr  <= 1'b0;
            r_buf_brk   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete && (!r_buf_valid || w_handshake)) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= r_shift;
                r_buf_perr  <= r_perr;
                r_buf_ferr  <= w_ferr_fin;
                r_buf_brk   <= w_brk;
            end else if (w_handshake) begin
                r_buf_valid <= 1'b0;
            end
            if (w_handshake) r_overrun <= 1'b0;
            else if (w_complete && r_buf_valid) r_overrun <= 1'b1;
        end
    end

    assign o_Rx_Data    = r_buf_data;
    assign o_Rx_Valid   = r_buf_valid;
    assign o_Parity_Err = r_buf_perr;
    assign o_Frame_Err  = r_buf_ferr;
    assign o_Break      = r_buf_brk;
    assign o_Overrun    = r_overrun;
    assign o_Busy       = (r_state != ST_IDLE);
    assign o_Dbg_State  = r_state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: serial-line driver tasks, expected-frame queue, per-scenario tests.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int DB = 8;
    localparam int EW = DB + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpb_in = 32'd16;
    logic        ld = 1'b0;
    logic [1:0]  pm = PAR_NONE;
    logic        two = 1'b0;
    logic        rx = 1'b1;
    logic        rdy = 1'b0;
    logic [DB-1:0] data;
    logic        valid, perr, ferr, brk, ovr, busy;
    rx_state_t   dbg;

    int errors = 0;
    int checks = 0;
    int cur_cpb = 16;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(DB), .CPB_W(32), .DEFAULT_CPB(16)) dut (
        .i_Clock(clk), .rst_n(rst_n), .i_Clks_Per_Bit(cpb_in), .i_Ld_Cfg(ld),
        .i_Parity_Mode(pm), .i_Two_Stop(two), .i_Rx_Serial(rx), .o_Rx_Data(data),
        .o_Rx_Valid(valid), .i_Rx_Ready(rdy), .o_Parity_Err(perr), .o_Frame_Err(ferr),
        .o_Break(brk), .o_Overrun(ovr), .o_Busy(busy), .o_Dbg_State(dbg)
    );

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    // par < 0: no parity bit. A final stop bit of 0 is cut short so the line idles soon after.
    task automatic send_frame(input logic [DB-1:0] d, input int par, input logic s1, input logic s2,
                              input bit use_s2, input int spike_bit, input int spike_off);
        send_bit(1'b0, cur_cpb);
        for (int i = 0; i < DB; i++) begin
            if (i == spike_bit) begin
                send_bit(d[i], spike_off);
                send_bit(~d[i], 1);
                send_bit(d[i], cur_cpb - spike_off - 1);
            end else begin
                send_bit(d[i], cur_cpb);
            end
        end
        if (par >= 0) send_bit(par[0], cur_cpb);
        if (use_s2) begin
            send_bit(s1, cur_cpb);
            send_bit(s2, s2 ? cur_cpb : cur_cpb / 2 + 3);
        end else begin
            send_bit(s1, s1 ? cur_cpb : cur_cpb / 2 + 3);
        end
        rx = 1'b1;
    endtask

    task automatic load_cfg(input int cpb, input logic [1:0] m, input logic t);
        cpb_in = 32'(cpb);
        pm = m;
        two = t;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        cur_cpb = (cpb < CPB_MIN) ? CPB_MIN : cpb;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, perr, ferr, brk, ovr, busy, data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b p=%b f=%b b=%b o=%b busy=%b d=%h want all 0",
                     valid, perr, ferr, brk, ovr, busy, data);
        end
        checks++;
        if (dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dbg, ST_IDLE);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_8n1();
        bit ok;
        logic [EW-1:0] got, exp;
        logic [DB-1:0] d;
        load_cfg(16, PAR_NONE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            exp_q.push_back({3'b000, d});
            send_frame(d, -1, 1'b1, 1'b1, 1'b0, -1, 0);
            wait_valid(2 * cur_cpb + 8, ok);
            got = {brk, ferr, perr, data};
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp || ovr !== 1'b0) begin
                errors++;
                $display("FAIL 8n1_frame%0d: valid=%b ovr=%b got %h want %h", i, ok, ovr, got, exp);
            end
            accept();
            checks++;
            if (valid !== 1'b0 || data !== d) begin
                errors++;
                $display("FAIL 8n1_accept%0d: valid=%b data=%h want valid=0 data=%h", i, valid, data, d);
            end
            idle(cur_cpb);
        end
    endtask

    task automatic test_parity();
        bit ok;
        logic [EW-1:0] got, exp;
        logic [DB-1:0] dv [4] = '{8'h03, 8'h03, 8'h07, 8'h07};
        int            pb [4] = '{1, 0, 0, 1};
        logic          pe [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            load_cfg(16, (i < 2) ? PAR_EVEN : PAR_ODD, 1'b0);
            exp_q.push_back({1'b0, 1'b0, pe[i], dv[i]});
            send_frame(dv[i], pb[i], 1'b1, 1'b1, 1'b0, -1, 0);
            wait_valid(2 * cur_cpb + 8, ok);
            got = {brk, ferr, perr, data};
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL parity_case%0d: valid=%b got %h want %h", i, ok, got, exp);
            end
            accept();
            idle(cur_cpb);
        end
    endtask

    task automatic test_stop();
        bit ok;
        logic [EW-1:0] got, exp;
        logic [DB-1:0] dv [3] = '{8'h5A, 8'h00, 8'hC6};
        logic          s1 [3] = '{1'b1, 1'b0, 1'b1};
        logic          s2 [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]    fl [3] = '{3'b010, 3'b110, 3'b000};
        load_cfg(16, PAR_NONE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({fl[i], dv[i]});
            send_frame(dv[i], -1, s1[i], s2[i], 1'b1, -1, 0);
            wait_valid(2 * cur_cpb + 8, ok);
            got = {brk, ferr, perr, data};
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL stop_case%0d: valid=%b got %h want %h", i, ok, got, exp);
            end
            accept();
            idle(2 * cur_cpb);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [EW+1:0] got, exp;
        load_cfg(16, PAR_NONE, 1'b0);
        rdy = 1'b0;
        exp_q.push_back({3'b000, 8'h11});
        send_frame(8'h11, -1, 1'b1, 1'b1, 1'b0, -1, 0);
        idle(cur_cpb);
        send_frame(8'h22, -1, 1'b1, 1'b1, 1'b0, -1, 0);
        idle(4);
        got = {ovr, valid, brk, ferr, perr, data};
        exp = {2'b11, exp_q.pop_front()};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL overrun_set: got %h want %h", got, exp);
        end
        accept();
        checks++;
        if (ovr !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b valid=%b want 0 0", ovr, valid);
        end
        idle(cur_cpb);
        exp_q.push_back({3'b000, 8'h33});
        send_frame(8'h33, -1, 1'b1, 1'b1, 1'b0, -1, 0);
        wait_valid(2 * cur_cpb + 8, ok);
        got = {ovr, valid, brk, ferr, perr, data};
        exp = {2'b01, exp_q.pop_front()};
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL overrun_after: got %h want %h", got, exp);
        end
        accept();
        idle(cur_cpb);
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] exp;
        int got_n;
        got_n = 0;
        rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    logic [DB-1:0] d;
                    d = 8'($urandom_range(0, 255));
                    exp_q.push_back({3'b000, d});
                    send_frame(d, -1, 1'b1, 1'b1, 1'b0, -1, 0);
                end
            end
            begin
                for (int c = 0; c < 40 * cur_cpb && got_n < 3; c++) begin
                    @(negedge clk);
                    if (valid) begin
                        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                        checks++;
                        if ({brk, ferr, perr, data} !== exp) begin
                            errors++;
                            $display("FAIL b2b_frame%0d: got %h want %h", got_n,
                                     {brk, ferr, perr, data}, exp);
                        end
                        got_n++;
                    end
                end
            end
        join
        checks++;
        if (got_n !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames want 3", got_n);
        end
        rdy = 1'b0;
        exp_q.delete();
        idle(2 * cur_cpb);
    endtask

    task automatic test_glitch();
        bit ok;
        logic [EW-1:0] got, exp;
        logic [DB-1:0] dv [3] = '{8'h5A, 8'hC3, 8'h0F};
        int            sb [3] = '{1, 4, 6};
        int            so [3] = '{6, 7, 8};
        load_cfg(16, PAR_NONE, 1'b0);
        send_bit(1'b0, 5);
        idle(3 * cur_cpb);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: valid=%b busy=%b want 0 0", valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'b000, dv[i]});
            send_frame(dv[i], -1, 1'b1, 1'b1, 1'b0, sb[i], so[i]);
            wait_valid(2 * cur_cpb + 8, ok);
            got = {brk, ferr, perr, data};
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL spike_case%0d: valid=%b got %h want %h", i, ok, got, exp);
            end
            accept();
            idle(cur_cpb);
        end
    endtask

    task automatic test_reset_cfg();
        bit ok;
        logic [EW-1:0] got, exp;
        send_bit(1'b0, 3 * cur_cpb);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, perr, ferr, brk, ovr, busy, data} !== '0 || dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL midframe_reset: v=%b busy=%b d=%h state=%0d want all 0",
                     valid, busy, data, dbg);
        end
        rst_n = 1'b1;
        cur_cpb = 16;
        idle(3 * cur_cpb);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_after: valid=%b busy=%b want 0 0", valid, busy);
        end
        load_cfg(2, PAR_NONE, 1'b0);
        for (int i = 0; i < 2; i++) begin
            logic [DB-1:0] d;
            d = (i == 0) ? 8'h3C : 8'h96;
            exp_q.push_back({3'b000, d});
            if (i == 0) begin
                send_frame(d, -1, 1'b1, 1'b1, 1'b0, -1, 0);
            end else begin
                // A config load attempted mid-frame must not change anything.
                fork
                    send_frame(d, -1, 1'b1, 1'b1, 1'b0, -1, 0);
                    begin
                        repeat (6) @(negedge clk);
                        cpb_in = 32'd16;
                        pm = PAR_ODD;
                        two = 1'b1;
                        ld = 1'b1;
                        @(negedge clk);
                        ld = 1'b0;
                    end
                join
            end
            wait_valid(2 * cur_cpb + 8, ok);
            got = {brk, ferr, perr, data};
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL clamp_cpb4_frame%0d: valid=%b got %h want %h", i, ok, got, exp);
            end
            accept();
            idle(4 * cur_cpb);
        end
        exp_q.push_back({3'b000, 8'h4B});
        send_frame(8'h4B, -1, 1'b1, 1'b1, 1'b0, -1, 0);
        wait_valid(2 * cur_cpb + 8, ok);
        got = {brk, ferr, perr, data};
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL busy_ld_ignored: valid=%b got %h want %h", ok, got, exp);
        end
        accept();
        idle(4 * cur_cpb);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_reset_cfg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
